// File: rtl/binario_a_bcd_secuencial_pkg.sv
// Shared definitions for the binary/BCD conversion paths of the calculator:
// FSM state encoding and default operand/digit widths.
package binario_a_bcd_secuencial_pkg;

    // States used by the shift-based conversion sequencers.
    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        FIN       = 2'd2
    } estado_t;

    // Default binary width (ALU result) and number of BCD digits for the display.
    localparam int ANCHO_DEF   = 16;
    localparam int DIGITOS_DEF = 5;

endpackage

// File: rtl/binario_a_bcd_secuencial_ajuste_bcd_digito.sv
// Per-digit correction step of the double dabble algorithm: a digit of 5 or
// more gets +3 so that the following left shift carries into the next digit.
module ajuste_bcd_digito
    import binario_a_bcd_secuencial_pkg::*;
(
    input  logic [3:0] i_digito,
    output logic [3:0] o_digito
);

    // Plain 4-bit add, no carry out: a valid digit (0..9) never exceeds 12 after the add.
    assign o_digito = (i_digito >= 4'd5) ? (i_digito + 4'd3) : i_digito;

endmodule

// File: rtl/binario_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per falling
// edge of reloj. Produces packed BCD digits plus a leading-zero mask that the
// display driver uses to blank unused digits.
module binario_a_bcd_secuencial
    import binario_a_bcd_secuencial_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int DIGITOS = DIGITOS_DEF
)
(
    input  logic                   reloj,
    input  logic                   reset_n,
    input  logic                   inicio,
    input  logic [ANCHO-1:0]       entrada_bin,
    output logic                   ocupado,
    output logic                   listo,
    output logic [4*DIGITOS-1:0]   salida_bcd,
    output logic [DIGITOS-1:0]     ceros_izq
);

    localparam int ANCHO_BCD = 4 * DIGITOS;
    localparam int ANCHO_CNT = $clog2(ANCHO + 1);
    // All digits flagged as leading zeros except digit 0, which always shows.
    localparam logic [DIGITOS-1:0] CEROS_REPOSO = {DIGITOS{1'b1}} ^ DIGITOS'(1);

    estado_t                r_estado;
    logic [ANCHO_BCD-1:0]   r_bcd;
    logic [ANCHO-1:0]       r_bin;
    logic [ANCHO_CNT-1:0]   r_contador;
    logic [ANCHO_BCD-1:0]   r_salida;
    logic [DIGITOS-1:0]     r_ceros;
    logic                   r_listo;

    logic [ANCHO_BCD-1:0]         w_bcdAjustado;
    logic [ANCHO_BCD+ANCHO-1:0]   w_desplazado;
    logic [DIGITOS-1:0]           w_ceros;

    // One correction cell per digit; digits never carry into each other here.
    for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
        ajuste_bcd_digito u_ajuste (
            .i_digito (r_bcd[4*g +: 4]),
            .o_digito (w_bcdAjustado[4*g +: 4])
        );
    end

    // The adjusted BCD field and the remaining binary bits move left together.
    assign w_desplazado = {w_bcdAjustado[ANCHO_BCD-2:0], r_bin, 1'b0};

    // Digit i is a leading zero when it and every more significant digit are zero.
    always_comb begin
        logic v_todoCero;
        w_ceros    = '0;
        v_todoCero = 1'b1;
        for (int i = DIGITOS - 1; i >= 1; i--) begin
            v_todoCero = v_todoCero & (r_bcd[4*i +: 4] == 4'd0);
            w_ceros[i] = v_todoCero;
        end
    end

    // Conversion sequencer: capture, ANCHO shift steps, then publish the result.
    always_ff @(negedge reloj) begin
        if (!reset_n) begin
            r_estado   <= REPOSO;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_contador <= '0;
            r_salida   <= '0;
            r_ceros    <= CEROS_REPOSO;
            r_listo    <= 1'b0;
        end else begin
            r_listo <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_bin      <= entrada_bin;
                        r_bcd      <= '0;
                        r_contador <= ANCHO_CNT'(ANCHO);
                        r_estado   <= CONVIERTE;
                    end
                end
                CONVIERTE: begin
                    r_bcd      <= w_desplazado[ANCHO_BCD+ANCHO-1:ANCHO];
                    r_bin      <= w_desplazado[ANCHO-1:0];
                    r_contador <= r_contador - ANCHO_CNT'(1);
                    if (r_contador == ANCHO_CNT'(1)) begin
                        r_estado <= FIN;
                    end
                end
                FIN: begin
                    r_salida <= r_bcd;
                    r_ceros  <= w_ceros;
                    r_listo  <= 1'b1;
                    r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    assign ocupado    = (r_estado != REPOSO);
    assign listo      = r_listo;
    assign salida_bcd = r_salida;
    assign ceros_izq  = r_ceros;

endmodule
